// File: rtl/commit_trace_checker.sv
// commit_trace_checker
//   Compares the processor's register-write commit stream against a reference
//   trace. Commits from NUM_CH writeback channels are queued in a small FIFO
//   (channel 0 oldest). Reference entries are paired with FIFO entries one per
//   cycle, and mismatches are reported and counted.
//
// Ports
//   clock, reset            sole clock (rising edge), synchronous active-high reset
//   wb_en/wb_rd/wb_wdata/wb_pc
//                           per-channel commit, channel i in slice i
//   ref_valid/ref_ready     reference entry handshake
//   ref_pc/ref_rd/ref_wdata reference entry fields
//   err_valid               one-cycle pulse after a mismatch
//   err_pc/err_rd/err_wdata/err_ref_pc
//                           mismatching entry, held until the next mismatch
//   inst_cnt, err_cnt       saturating commit and mismatch counters
//   state                   IDLE=0, RUN=1, HALT=2, DONE=3
//   overflow                sticky, set when a commit could not be queued
module commit_trace_checker #(
    parameter int          NUM_CH      = 2,
    parameter int          DEPTH       = 8,
    parameter logic [31:0] BEGIN_PC    = 32'hbfc00000,
    parameter logic [31:0] END_PC      = 32'hbfc00100,
    parameter logic [31:0] SKIP_MASK   = 32'hfffffff8,
    parameter logic [31:0] SKIP_BASE   = 32'hbfc00380,
    parameter bit          STOP_ON_ERR = 1'b0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_CH-1:0]    wb_en,
    input  logic [5*NUM_CH-1:0]  wb_rd,
    input  logic [32*NUM_CH-1:0] wb_wdata,
    input  logic [32*NUM_CH-1:0] wb_pc,
    input  logic                 ref_valid,
    output logic                 ref_ready,
    input  logic [31:0]          ref_pc,
    input  logic [4:0]           ref_rd,
    input  logic [31:0]          ref_wdata,
    output logic                 err_valid,
    output logic [31:0]          err_pc,
    output logic [4:0]           err_rd,
    output logic [31:0]          err_wdata,
    output logic [31:0]          err_ref_pc,
    output logic [31:0]          inst_cnt,
    output logic [15:0]          err_cnt,
    output logic [1:0]           state,
    output logic                 overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [31:0] mem_pc    [DEPTH];
    logic [4:0]  mem_rd    [DEPTH];
    logic [31:0] mem_wdata [DEPTH];

    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg, count_next;
    logic [1:0]    state_reg, state_next;
    logic          err_valid_reg;
    logic [31:0]   err_pc_reg, err_wdata_reg, err_ref_pc_reg;
    logic [4:0]    err_rd_reg;
    logic [31:0]   inst_cnt_reg;
    logic [15:0]   err_cnt_reg;
    logic          overflow_reg;

    logic [NUM_CH-1:0] push_req, push_ok;
    logic [CW-1:0]     rank [NUM_CH];
    logic [CW-1:0]     free_slots;
    logic [CW-1:0]     push_cnt;
    logic [31:0]       en_cnt;
    logic [32:0]       inst_sum;

    // Space is judged on the start-of-cycle occupancy, so a pop in the same
    // cycle never makes room for an extra push.
    assign free_slots = CW'(DEPTH) - count_reg;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign push_req[gi] = wb_en[gi] && (wb_rd[5*gi +: 5] != 5'd0) && (state_reg != S_DONE);
            // rank = number of older requesting channels; lowest channels win.
            assign push_ok[gi]  = push_req[gi] && (rank[gi] < free_slots);
        end
    endgenerate

    always_comb begin
        logic [CW-1:0] acc;
        acc      = '0;
        push_cnt = '0;
        en_cnt   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            rank[i]  = acc;
            acc      = acc + CW'(push_req[i]);
            push_cnt = push_cnt + CW'(push_ok[i]);
            en_cnt   = en_cnt + 32'(wb_en[i]);
        end
    end

    assign inst_sum = {1'b0, inst_cnt_reg} + {1'b0, en_cnt};

    // Head of the queue, read combinationally so the pairing happens the
    // same cycle the reference entry is offered.
    logic [31:0] head_pc, head_wdata;
    logic [4:0]  head_rd;
    assign head_pc    = mem_pc[rd_ptr_reg];
    assign head_rd    = mem_rd[rd_ptr_reg];
    assign head_wdata = mem_wdata[rd_ptr_reg];

    logic fifo_nonempty, hs_run, is_end, exempt, mismatch;
    assign fifo_nonempty = (count_reg != '0);
    assign hs_run        = (state_reg == S_RUN) && ref_valid && fifo_nonempty;
    assign is_end        = (ref_pc == END_PC);
    assign exempt        = ((head_pc & SKIP_MASK) == SKIP_BASE);
    assign mismatch      = hs_run && !is_end && !exempt &&
                           ((head_pc != ref_pc) || (head_rd != ref_rd) || (head_wdata != ref_wdata));

    always_comb begin
        ref_ready = 1'b0;
        case (state_reg)
            S_IDLE:  ref_ready = ref_valid && (ref_pc != BEGIN_PC);
            S_RUN:   ref_ready = ref_valid && fifo_nonempty;
            default: ref_ready = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (ref_valid && (ref_pc == BEGIN_PC)) state_next = S_RUN;
            S_RUN: begin
                if (hs_run && is_end)               state_next = S_DONE;
                else if (mismatch && STOP_ON_ERR)   state_next = S_HALT;
            end
            default: state_next = state_reg;
        endcase
    end

    assign count_next = count_reg + push_cnt - CW'(hs_run);

    // Queue storage; each accepted channel lands at its rank past the tail.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (push_ok[i]) begin
                mem_pc[wr_ptr_reg + AW'(rank[i])]    <= wb_pc[32*i +: 32];
                mem_rd[wr_ptr_reg + AW'(rank[i])]    <= wb_rd[5*i +: 5];
                mem_wdata[wr_ptr_reg + AW'(rank[i])] <= wb_wdata[32*i +: 32];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            state_reg      <= S_IDLE;
            err_valid_reg  <= 1'b0;
            err_pc_reg     <= '0;
            err_rd_reg     <= '0;
            err_wdata_reg  <= '0;
            err_ref_pc_reg <= '0;
            inst_cnt_reg   <= '0;
            err_cnt_reg    <= '0;
            overflow_reg   <= 1'b0;
        end else begin
            wr_ptr_reg    <= wr_ptr_reg + AW'(push_cnt);
            rd_ptr_reg    <= rd_ptr_reg + AW'(hs_run);
            count_reg     <= count_next;
            state_reg     <= state_next;
            err_valid_reg <= mismatch;
            if (mismatch) begin
                err_pc_reg     <= head_pc;
                err_rd_reg     <= head_rd;
                err_wdata_reg  <= head_wdata;
                err_ref_pc_reg <= ref_pc;
                if (err_cnt_reg != 16'hffff) err_cnt_reg <= err_cnt_reg + 16'd1;
            end
            if (state_reg != S_DONE)
                inst_cnt_reg <= inst_sum[32] ? 32'hffffffff : inst_sum[31:0];
            if ((push_req & ~push_ok) != '0) overflow_reg <= 1'b1;
        end
    end

    assign err_valid  = err_valid_reg;
    assign err_pc     = err_pc_reg;
    assign err_rd     = err_rd_reg;
    assign err_wdata  = err_wdata_reg;
    assign err_ref_pc = err_ref_pc_reg;
    assign inst_cnt   = inst_cnt_reg;
    assign err_cnt    = err_cnt_reg;
    assign state      = state_reg;
    assign overflow   = overflow_reg;

endmodule
